// File: rtl/fifo_wconv_sync.sv
// fifo_wconv_sync
// ---------------
// Single-clock FIFO with write/read width conversion (upsizing or downsizing).
// Storage is counted in base units of min(WR_DATA_WIDTH, RD_DATA_WIDTH) bits.
// Lanes are LSB-first: the oldest base unit lands in the lowest bits of a wide
// read word, and a wide write word is consumed lowest slice first.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write request / write word
//   wr_full           fewer free units than one write word
//   almost_full       wr_water_level >= almost_full_th
//   wr_water_level    stored data in write-word units (floored)
//   wr_overflow       one-cycle pulse after a rejected write
//   rd_en, rd_data    read request / read word
//   rd_empty          fewer stored units than one read word
//   almost_empty      rd_water_level <= almost_empty_th
//   rd_water_level    stored data in read-word units (floored)
//   rd_underflow      one-cycle pulse after a rejected read
//   almost_full_th    threshold in write units, live input
//   almost_empty_th   threshold in read units, live input
//
// ADDR_WIDTH must be larger than log2(max(WR,RD)/min(WR,RD)) so that each
// lane memory has at least two rows.
module fifo_wconv_sync #(
    parameter int  WR_DATA_WIDTH = 32,
    parameter int  RD_DATA_WIDTH = 256,
    parameter int  ADDR_WIDTH    = 10,
    parameter int  FWFT          = 0,
    localparam int WL_W          = ADDR_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [WL_W-1:0]          wr_water_level,
    output logic                     wr_overflow,
    input  logic                     rd_en,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [WL_W-1:0]          rd_water_level,
    output logic                     rd_underflow,
    input  logic [WL_W-1:0]          almost_full_th,
    input  logic [WL_W-1:0]          almost_empty_th
);

    localparam int B    = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WU   = WR_DATA_WIDTH / B;
    localparam int RU   = RD_DATA_WIDTH / B;
    localparam int M    = (WU > RU) ? WU : RU;      // number of lane memories
    localparam int LWU  = $clog2(WU);
    localparam int LRU  = $clog2(RU);
    localparam int LM   = $clog2(M);
    localparam int LMW  = (LM > 0) ? LM : 1;
    localparam int RW   = ADDR_WIDTH - LM;          // row address width per lane
    localparam int ROWS = 1 << RW;

    localparam logic [WL_W-1:0] DEPTH = WL_W'(1 << ADDR_WIDTH);
    localparam logic [WL_W-1:0] WU_C  = WL_W'(WU);
    localparam logic [WL_W-1:0] RU_C  = WL_W'(RU);

    logic [WL_W-1:0]       cnt_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic                  wr_overflow_reg;
    logic                  rd_underflow_reg;

    logic                  wacc;
    logic                  racc;
    logic [WL_W-1:0]       free_space;
    logic [RW-1:0]         wr_row;
    logic [RW-1:0]         rd_row;
    logic [M-1:0]          lane_we;
    logic [M-1:0][B-1:0]   lane_wdata;
    logic [M-1:0][B-1:0]   lane_out;
    logic [RD_DATA_WIDTH-1:0] head_word;

    // Status decodes only from the registered count and the threshold inputs.
    assign free_space     = DEPTH - cnt_reg;
    assign wr_full        = free_space < WU_C;
    assign rd_empty       = cnt_reg < RU_C;
    assign wr_water_level = cnt_reg >> LWU;
    assign rd_water_level = cnt_reg >> LRU;
    assign almost_full    = wr_water_level >= almost_full_th;
    assign almost_empty   = rd_water_level <= almost_empty_th;
    assign wr_overflow    = wr_overflow_reg;
    assign rd_underflow   = rd_underflow_reg;

    // Acceptance uses pre-edge flags, so a same-cycle read never frees room
    // for a write and a same-cycle write never makes a read legal.
    assign wacc = wr_en & ~wr_full;
    assign racc = rd_en & ~rd_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg          <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            wr_overflow_reg  <= 1'b0;
            rd_underflow_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + (wacc ? WU_C : '0) - (racc ? RU_C : '0);
            if (wacc) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(WU);
            end
            if (racc) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(RU);
            end
            wr_overflow_reg  <= wr_en & wr_full;
            rd_underflow_reg <= rd_en & rd_empty;
        end
    end

    // Pointers are in base units; the upper bits select a row shared by all
    // lanes, the lower LM bits select the lane for the narrow side.
    assign wr_row = wr_ptr_reg[ADDR_WIDTH-1:LM];
    assign rd_row = rd_ptr_reg[ADDR_WIDTH-1:LM];

    // Write side: a wide write fills every lane of one row, a narrow write
    // fills the single lane addressed by the pointer's low bits.
    if (WU == M) begin : g_wr_wide
        logic unused_wr_lane_bits;
        assign unused_wr_lane_bits = ^wr_ptr_reg[LMW-1:0];
        assign lane_we    = {M{wacc}};
        assign lane_wdata = wr_data;
    end else begin : g_wr_narrow
        logic [LMW-1:0] wr_lane;
        assign wr_lane    = wr_ptr_reg[LMW-1:0];
        assign lane_wdata = {M{wr_data}};
        for (genvar gi = 0; gi < M; gi++) begin : g_we
            assign lane_we[gi] = wacc && (wr_lane == LMW'(gi));
        end
    end

    // One memory per lane. The read port is combinational so the head word is
    // visible in the same cycle for fall-through mode; standard mode registers
    // it below, which still maps onto a RAM with a registered output.
    for (genvar gi = 0; gi < M; gi++) begin : g_lane
        logic [B-1:0] mem [ROWS];
        always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
                mem[wr_row] <= lane_wdata[gi];
            end
        end
        assign lane_out[gi] = mem[rd_row];
    end

    // Read side: a wide read gathers every lane (lane 0 in the LSBs), a narrow
    // read picks the lane addressed by the read pointer.
    if (RU == M) begin : g_rd_wide
        logic unused_rd_lane_bits;
        assign unused_rd_lane_bits = ^rd_ptr_reg[LMW-1:0];
        assign head_word = lane_out;
    end else begin : g_rd_narrow
        logic [LMW-1:0] rd_lane;
        assign rd_lane   = rd_ptr_reg[LMW-1:0];
        assign head_word = lane_out[rd_lane];
    end

    if (FWFT != 0) begin : g_fwft
        // Forced to zero while empty so reset shows a clean output.
        assign rd_data = rd_empty ? '0 : head_word;
    end else begin : g_std
        logic [RD_DATA_WIDTH-1:0] rd_data_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_reg <= '0;
            end else if (racc) begin
                rd_data_reg <= head_word;
            end
        end
        assign rd_data = rd_data_reg;
    end

endmodule

// File: tb/tb_fifo_wconv_sync.sv
`timescale 1ns/1ps
// Bench for fifo_wconv_sync: one upsizing instance (32->256, standard read)
// and one downsizing instance (256->32, fall-through read) share clock and
// reset. A queue-of-units model predicts every output each cycle; directed
// steps pin the model with literal values.
module tb_fifo_wconv_sync;
    localparam int AW   = 10;
    localparam int WL_W = AW + 1;
    localparam int CAP  = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // upsizing instance
    logic            u_wr_en = 1'b0;
    logic [31:0]     u_wr_data = '0;
    logic            u_wr_full, u_af, u_ovf, u_rd_empty, u_ae, u_unf;
    logic [WL_W-1:0] u_wwl, u_rwl;
    logic            u_rd_en = 1'b0;
    logic [255:0]    u_rd_data;
    logic [WL_W-1:0] u_af_th = 11'd1020;
    logic [WL_W-1:0] u_ae_th = 11'd4;

    // downsizing instance
    logic            d_wr_en = 1'b0;
    logic [255:0]    d_wr_data = '0;
    logic            d_wr_full, d_af, d_ovf, d_rd_empty, d_ae, d_unf;
    logic [WL_W-1:0] d_wwl, d_rwl;
    logic            d_rd_en = 1'b0;
    logic [31:0]     d_rd_data;
    logic [WL_W-1:0] d_af_th = 11'd120;
    logic [WL_W-1:0] d_ae_th = 11'd4;

    fifo_wconv_sync #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(256), .ADDR_WIDTH(AW), .FWFT(0)) dut_up (
        .clk(clk), .rst_n(rst_n),
        .wr_en(u_wr_en), .wr_data(u_wr_data), .wr_full(u_wr_full), .almost_full(u_af),
        .wr_water_level(u_wwl), .wr_overflow(u_ovf),
        .rd_en(u_rd_en), .rd_data(u_rd_data), .rd_empty(u_rd_empty), .almost_empty(u_ae),
        .rd_water_level(u_rwl), .rd_underflow(u_unf),
        .almost_full_th(u_af_th), .almost_empty_th(u_ae_th)
    );

    fifo_wconv_sync #(.WR_DATA_WIDTH(256), .RD_DATA_WIDTH(32), .ADDR_WIDTH(AW), .FWFT(1)) dut_dn (
        .clk(clk), .rst_n(rst_n),
        .wr_en(d_wr_en), .wr_data(d_wr_data), .wr_full(d_wr_full), .almost_full(d_af),
        .wr_water_level(d_wwl), .wr_overflow(d_ovf),
        .rd_en(d_rd_en), .rd_data(d_rd_data), .rd_empty(d_rd_empty), .almost_empty(d_ae),
        .rd_water_level(d_rwl), .rd_underflow(d_unf),
        .almost_full_th(d_af_th), .almost_empty_th(d_ae_th)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: queues of 32-bit units ----------------
    logic [31:0]  uq[$];
    logic [31:0]  dq[$];
    logic [255:0] m_u_rd  = '0;
    logic         m_u_ovf = 1'b0, m_u_unf = 1'b0, m_d_ovf = 1'b0, m_d_unf = 1'b0;

    initial forever begin
        bit w, r;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            uq.delete();
            dq.delete();
            m_u_rd  = '0;
            m_u_ovf = 1'b0; m_u_unf = 1'b0;
            m_d_ovf = 1'b0; m_d_unf = 1'b0;
        end else begin
            // upsizer: one unit per write, eight per read
            w = u_wr_en && (CAP - uq.size() >= 1);
            r = u_rd_en && (uq.size() >= 8);
            m_u_ovf = u_wr_en && !w;
            m_u_unf = u_rd_en && !r;
            if (r) begin
                for (int k = 0; k < 8; k++) m_u_rd[k*32 +: 32] = uq[k];
                repeat (8) void'(uq.pop_front());
            end
            if (w) uq.push_back(u_wr_data);
            // downsizer: eight units per write, one per read
            w = d_wr_en && (CAP - dq.size() >= 8);
            r = d_rd_en && (dq.size() >= 1);
            m_d_ovf = d_wr_en && !w;
            m_d_unf = d_rd_en && !r;
            if (r) void'(dq.pop_front());
            if (w) for (int k = 0; k < 8; k++) dq.push_back(d_wr_data[k*32 +: 32]);
        end
    end

    // ---------------- per-cycle compare, away from the active edge ----------------
    initial forever begin
        int us, ds;
        @(negedge clk);
        us = uq.size();
        ds = dq.size();
        chk("u_wr_full",  u_wr_full,  (CAP - us) < 1);
        chk("u_rd_empty", u_rd_empty, us < 8);
        chk("u_wwl",      u_wwl,      us);
        chk("u_rwl",      u_rwl,      us / 8);
        chk("u_af",       u_af,       us >= int'(u_af_th));
        chk("u_ae",       u_ae,       (us / 8) <= int'(u_ae_th));
        chk("u_ovf",      u_ovf,      m_u_ovf);
        chk("u_unf",      u_unf,      m_u_unf);
        chk("u_rd_data",  u_rd_data,  m_u_rd);
        chk("d_wr_full",  d_wr_full,  (CAP - ds) < 8);
        chk("d_rd_empty", d_rd_empty, ds < 1);
        chk("d_wwl",      d_wwl,      ds / 8);
        chk("d_rwl",      d_rwl,      ds);
        chk("d_af",       d_af,       (ds / 8) >= int'(d_af_th));
        chk("d_ae",       d_ae,       ds <= int'(d_ae_th));
        chk("d_ovf",      d_ovf,      m_d_ovf);
        chk("d_unf",      d_unf,      m_d_unf);
        if (ds > 0) chk("d_rd_data", d_rd_data, dq[0]);
    end

    // Advance one cycle: past the edge and the compare, then settle.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int pw_u[3] = '{95, 10, 50};
    int pr_u[3] = '{5, 70, 7};
    int pw_d[3] = '{20, 5, 12};
    int pr_d[3] = '{40, 95, 90};
    int ncyc[3] = '{2000, 800, 1000};

    initial begin
        logic [255:0] lanes;
        int           guard;

        nxt(); nxt();
        // reset state
        chk("rst_u_rd_empty", u_rd_empty, 1);
        chk("rst_u_wwl", u_wwl, 0);
        chk("rst_u_af", u_af, 0);
        chk("rst_u_ae", u_ae, 1);
        chk("rst_d_rd_empty", d_rd_empty, 1);
        chk("rst_d_wr_full", d_wr_full, 0);
        $display("txn reset checked");
        rst_n = 1'b1;
        nxt();

        // upsize: eight words 0..7 make one read word
        for (int i = 0; i < 8; i++) begin
            u_wr_en = 1'b1; u_wr_data = i; nxt();
            $display("txn up write %0h", i);
        end
        u_wr_en = 1'b0;
        chk("up8_rd_empty", u_rd_empty, 0);
        chk("up8_rwl", u_rwl, 1);
        chk("up8_wwl", u_wwl, 8);
        u_rd_en = 1'b1; nxt(); u_rd_en = 1'b0;
        lanes = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
        chk("up8_rd_data", u_rd_data, lanes);
        chk("up8_rd_empty_after", u_rd_empty, 1);
        $display("txn up read %0h", u_rd_data);

        // fill to full, probing the thresholds on the way
        for (int i = 0; i < CAP; i++) begin
            u_wr_en = 1'b1; u_wr_data = $urandom; nxt();
            if (i == 38)   chk("ae_at_4_words", u_ae, 1);
            if (i == 39)   chk("ae_at_5_words", u_ae, 0);
            if (i == 1018) chk("af_at_1019", u_af, 0);
            if (i == 1019) chk("af_at_1020", u_af, 1);
        end
        $display("txn up fill %0d writes", CAP);
        chk("full_wr_full", u_wr_full, 1);
        chk("full_wwl", u_wwl, 1024);
        chk("full_rwl", u_rwl, 128);
        u_wr_data = 32'hDEAD_BEEF; nxt(); u_wr_en = 1'b0;
        chk("ovf_pulse", u_ovf, 1);
        chk("ovf_wwl", u_wwl, 1024);
        nxt();
        chk("ovf_clear", u_ovf, 0);
        $display("txn up overflow write");

        // simultaneous read and write while full
        u_wr_en = 1'b1; u_rd_en = 1'b1; nxt(); u_wr_en = 1'b0; u_rd_en = 1'b0;
        chk("sim_ovf", u_ovf, 1);
        chk("sim_wwl", u_wwl, 1016);
        chk("sim_wr_full", u_wr_full, 0);
        $display("txn up simultaneous at full");

        // drain, then one rejected read
        guard = 0;
        while (!u_rd_empty && guard < 200) begin
            u_rd_en = 1'b1; nxt(); guard++;
            if (u_rwl == 4) chk("ae_after_read_from_5", u_ae, 1);
        end
        u_rd_en = 1'b0;
        chk("drain_guard", guard < 200, 1);
        u_rd_en = 1'b1; nxt(); u_rd_en = 1'b0;
        chk("up_unf_pulse", u_unf, 1);
        $display("txn up drained in %0d reads", guard);

        // downsize, fall-through
        d_wr_en = 1'b1;
        d_wr_data = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
        nxt(); d_wr_en = 1'b0;
        chk("dn_head", d_rd_data, 0);
        chk("dn_rwl", d_rwl, 8);
        chk("dn_wwl", d_wwl, 1);
        for (int k = 0; k < 8; k++) begin
            chk("dn_word", d_rd_data, k);
            d_rd_en = 1'b1; nxt();
            if (k == 0) chk("dn_wwl_after_1", d_wwl, 0);
            $display("txn dn read %0d", k);
        end
        nxt(); d_rd_en = 1'b0;
        chk("dn_unf_pulse", d_unf, 1);
        chk("dn_empty", d_rd_empty, 1);

        // reset mid-run with 300 units stored
        for (int i = 0; i < 300; i++) begin
            u_wr_en = 1'b1; u_wr_data = $urandom; nxt();
        end
        u_wr_en = 1'b0;
        chk("pre_rst_wwl", u_wwl, 300);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_empty", u_rd_empty, 1);
        chk("midrst_wwl", u_wwl, 0);
        chk("midrst_rwl", u_rwl, 0);
        chk("midrst_rd_data", u_rd_data, 0);
        $display("txn mid-run reset");
        nxt();
        rst_n = 1'b1;
        nxt();
        for (int i = 0; i < 8; i++) begin
            u_wr_en = 1'b1; u_wr_data = (i == 0) ? 32'hA5 : 32'(i); nxt();
        end
        u_wr_en = 1'b0;
        u_rd_en = 1'b1; nxt(); u_rd_en = 1'b0;
        lanes = u_rd_data;
        chk("post_rst_a5", lanes[31:0], 32'hA5);
        $display("txn post-reset read %0h", lanes[31:0]);

        // randomized traffic in three pressure phases
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < ncyc[p]; c++) begin
                if (c % 64 == 0) begin
                    u_af_th = 11'($urandom_range(0, 1100));
                    u_ae_th = 11'($urandom_range(0, 140));
                    d_af_th = 11'($urandom_range(0, 140));
                    d_ae_th = 11'($urandom_range(0, 1100));
                end
                u_wr_en   = ($urandom_range(0, 99) < pw_u[p]);
                u_rd_en   = ($urandom_range(0, 99) < pr_u[p]);
                u_wr_data = $urandom;
                d_wr_en   = ($urandom_range(0, 99) < pw_d[p]);
                d_rd_en   = ($urandom_range(0, 99) < pr_d[p]);
                for (int k = 0; k < 8; k++) d_wr_data[k*32 +: 32] = $urandom;
                nxt();
            end
            $display("txn random phase %0d done, up=%0d dn=%0d units", p, uq.size(), dq.size());
        end
        u_wr_en = 1'b0; u_rd_en = 1'b0; d_wr_en = 1'b0; d_rd_en = 1'b0;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
